rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 The block SHALL have parameter BW_DATA, default 32, meaning data width per input.
REQ-002 The block SHALL have parameter IN_NUM, default 4, meaning number of requesters (any value 2..16, not only powers of two).
REQ-003 The block SHALL use localparam BW_SEL = $clog2(IN_NUM) as the select width.
REQ-004 i_clk  input  1  rising-edge clock; the block SHALL have only this one clock.
REQ-005 i_rstn  input  1  reset; it SHALL be asynchronous and active-low.
REQ-006 i_req  input  IN_NUM  per-requester valid; bit k means input k has data.
REQ-007 i_in  input  IN_NUM*BW_DATA  flattened packed data bus; input k occupies bits [k*BW_DATA +: BW_DATA]; the port SHALL NOT be an unpacked array.
REQ-008 o_gnt  output  IN_NUM  one-hot grant (combinational); bit k high means input k transfers this cycle.
REQ-009 o_sel  output  BW_SEL  registered index of the input whose data is in o_out.
REQ-010 o_valid  output  1  output register holds valid data.
REQ-011 o_out  output  BW_DATA  registered data of the granted input.
REQ-012 i_ready  input  1  downstream accepts o_out this cycle.

Function
REQ-013 Handshake: an input transfer SHALL occur when i_req[k] && o_gnt[k]; an output transfer SHALL occur when o_valid && i_ready.
REQ-014 FSM states: S_EMPTY (o_valid=0) and S_FULL (o_valid=1); o_valid SHALL equal (state == S_FULL).
REQ-015 Accept condition acc = (state==S_EMPTY) || i_ready; o_gnt SHALL be all-zero when !acc or i_req==0.
REQ-016 When acc and i_req!=0, o_gnt SHALL have exactly one bit set: the first requesting index found searching upward from pointer ptr, wrapping IN_NUM-1 -> 0.
REQ-017 On an input transfer from index k, the next cycle SHALL have o_out = i_in slice k, o_sel = k, state = S_FULL, and ptr = (k+1) mod IN_NUM (k = IN_NUM-1 -> ptr = 0).
REQ-018 Latency: i_req to o_valid SHALL be exactly 1 cycle when the output register is empty or drained that same cycle.
REQ-019 Transitions: S_EMPTY -> S_FULL on an input transfer; S_FULL -> S_EMPTY on an output transfer with no input transfer; S_FULL -> S_FULL on an output transfer plus a simultaneous input transfer (back-to-back, no bubble), or on stall.
REQ-020 Stall (S_FULL && !i_ready): o_out, o_sel, o_valid and ptr SHALL hold, and o_gnt SHALL be 0.
REQ-021 ptr SHALL change only on an input transfer; idle cycles SHALL NOT move it.
REQ-022 A requester SHALL wait at most IN_NUM-1 other grants while it holds i_req (no starvation).
REQ-023 Inputs with i_req=0 SHALL never be granted; data on non-requesting slices SHALL be ignored.
REQ-024 ptr SHALL never take a value >= IN_NUM (non-power-of-two IN_NUM).

Reset
REQ-025 While i_rstn=0: state=S_EMPTY, o_valid=0, o_out=0, o_sel=0, ptr=0, o_gnt=0 (gated by reset), asynchronously and independent of i_clk.
REQ-026 Reset asserted mid-operation SHALL discard any held o_out; the first grant after release SHALL start the search at index 0.
REQ-027 Deassertion SHALL take effect at the first i_clk edge after i_rstn rises; no transfer SHALL occur in the reset cycle.

Verification (IN_NUM=4, BW_DATA=32, input k data = 32'hA000_000k)
REQ-028 Reset then i_req=4'b0000 for 5 cycles -> o_valid=0, o_gnt=0, o_out=0, ptr=0 throughout.
REQ-029 i_req=4'b1111 held, i_ready=1 -> o_gnt sequence 0001,0010,0100,1000,0001; o_sel 0,1,2,3,0 one cycle later; o_valid stays 1 with no bubble.
REQ-030 i_req=4'b1010, ptr=0 -> grant 0010 (o_out=32'hA000_0001); next grant 1000 (o_out=32'hA000_0003); then wrap back to 0010.
REQ-031 o_valid=1, o_sel=2, i_ready=0 for 3 cycles with i_req=4'b1111 -> o_gnt=0, o_out=32'hA000_0002 stable; on i_ready=1 -> o_gnt=1000 that cycle.
REQ-032 Single i_req=4'b0100 pulse with i_ready=1 -> o_valid high for exactly 1 cycle, o_sel=2, then S_EMPTY.
REQ-033 i_rstn pulled low while o_valid=1, o_sel=3 -> o_valid=0 and o_out=0 immediately (before the next edge); after release, i_req=4'b1111 -> first grant 0001.

Source files
------------

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a single registered output stage.
// IN_NUM requesters each present BW_DATA-bit data on a flattened bus. One
// requester per cycle is granted, searching upward from a rotating pointer,
// and its data is captured into the output register. The output register
// can be refilled in the same cycle it drains, so back-to-back traffic has
// no bubbles.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_EMPTY | output register holds nothing; any request may be accepted
// S_FULL  | o_out/o_sel hold data; accept a new input only if i_ready
module rr_arbiter #(
  parameter int BW_DATA = 32,
  parameter int IN_NUM  = 4,
  localparam int BW_SEL = $clog2(IN_NUM)
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [IN_NUM-1:0]          i_req,
  input  logic [IN_NUM*BW_DATA-1:0]  i_in,
  input  logic                       i_ready,
  output logic [IN_NUM-1:0]          o_gnt,
  output logic [BW_SEL-1:0]          o_sel,
  output logic                       o_valid,
  output logic [BW_DATA-1:0]         o_out
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam logic [BW_SEL-1:0] LAST_IDX = BW_SEL'(IN_NUM - 1);

  state_t                r_state;
  logic [BW_SEL-1:0]     r_ptr;
  logic [BW_SEL-1:0]     r_sel;
  logic [BW_DATA-1:0]    r_out;

  logic                  w_acc;
  logic                  w_found;
  logic [BW_SEL-1:0]     w_idx;
  logic [IN_NUM-1:0]     w_gnt;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic [BW_DATA-1:0]    w_slice;
  int                    w_j;

  // Room for a new word when empty, or when the held word leaves this cycle.
  assign w_acc      = (r_state == S_EMPTY) || i_ready;
  assign w_out_xfer = (r_state == S_FULL) && i_ready;

  // Find the first requester at or above the pointer, wrapping at IN_NUM-1.
  // The modulo keeps the search inside the valid index range even when
  // IN_NUM is not a power of two.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_j     = 0;
    for (int i = 0; i < IN_NUM; i++) begin
      w_j = (int'(r_ptr) + i) % IN_NUM;
      if (!w_found && i_req[w_j]) begin
        w_found = 1'b1;
        w_idx   = BW_SEL'(w_j);
      end
    end
  end

  // One-hot grant; suppressed while stalled, idle, or held in reset.
  always_comb begin
    w_gnt = '0;
    if (i_rstn && w_acc && w_found) begin
      w_gnt[w_idx] = 1'b1;
    end
  end

  assign w_in_xfer = |(w_gnt & i_req);
  assign w_slice   = i_in[int'(w_idx)*BW_DATA +: BW_DATA];

  // Output-stage FSM: capture granted data, advance the pointer past the
  // winner, and drain when downstream accepts with nothing new arriving.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_EMPTY;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_state <= S_FULL;
            r_out   <= w_slice;
            r_sel   <= w_idx;
            r_ptr   <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
          end
        end
        S_FULL: begin
          if (w_in_xfer) begin
            r_state <= S_FULL;
            r_out   <= w_slice;
            r_sel   <= w_idx;
            r_ptr   <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
          end else if (w_out_xfer) begin
            r_state <= S_EMPTY;
          end
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  assign o_gnt   = w_gnt;
  assign o_sel   = r_sel;
  assign o_out   = r_out;
  assign o_valid = (r_state == S_FULL);

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (IN_NUM=4, BW_DATA=32, input k = A000_000k).
module tb_rr_arbiter;

  logic          clk;
  logic          rstn;
  logic [3:0]    req;
  logic [127:0]  din;
  logic          ready;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          valid;
  logic [31:0]   dout;

  int errors = 0;
  int checks = 0;

  rr_arbiter #(.BW_DATA(32), .IN_NUM(4)) dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_req   (req),
    .i_in    (din),
    .i_ready (ready),
    .o_gnt   (gnt),
    .o_sel   (sel),
    .o_valid (valid),
    .o_out   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s,
                         input logic [31:0] d, input logic [3:0] g);
    chk({tag, "_valid"}, 32'(valid), 32'(v));
    chk({tag, "_sel"},   32'(sel),   32'(s));
    chk({tag, "_out"},   dout,       d);
    chk({tag, "_gnt"},   32'(gnt),   32'(g));
  endtask

  logic [3:0] rr_gnt [5];

  initial begin
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    din   = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    rstn  = 1'b0;
    req   = 4'b0000;
    ready = 1'b1;

    // Reset state before any clock edge, grant gated while in reset.
    #2;
    chk_out("rst", 1'b0, 2'd0, 32'h0, 4'b0000);
    req = 4'b1111;
    #1;
    chk("rst_gnt_gated", 32'(gnt), 32'h0);
    cyc();
    cyc();
    chk("rst_no_xfer", 32'(valid), 32'h0);
    req = 4'b0000;
    #2;
    rstn = 1'b1;

    // Idle for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_out("idle", 1'b0, 2'd0, 32'h0, 4'b0000);
    end

    // All requesting: rotation 0,1,2,3,0 with no bubble.
    cyc();
    req = 4'b1111;
    #1;
    chk("rr_gnt0", 32'(gnt), 32'(rr_gnt[0]));
    for (int i = 1; i < 5; i++) begin
      cyc();
      chk_out("rr", 1'b1, 2'(i - 1), 32'hA000_0000 + 32'(i - 1), rr_gnt[i]);
    end
    cyc();
    req = 4'b0000;
    #1;
    chk_out("rr_last", 1'b1, 2'd0, 32'hA000_0000, 4'b0000);
    cyc();
    chk("rr_drain", 32'(valid), 32'h0);

    // ptr is 1; grant index 3 alone to bring it to 0.
    cyc();
    req = 4'b1000;
    #1;
    chk("p3_gnt", 32'(gnt), 32'h8);
    cyc();
    req = 4'b0000;
    #1;
    chk_out("p3", 1'b1, 2'd3, 32'hA000_0003, 4'b0000);
    cyc();
    chk("p3_drain", 32'(valid), 32'h0);

    // Sparse request 1010 from ptr 0.
    cyc();
    req = 4'b1010;
    #1;
    chk("sp_gnt1", 32'(gnt), 32'h2);
    cyc();
    chk_out("sp_a", 1'b1, 2'd1, 32'hA000_0001, 4'b1000);
    cyc();
    chk_out("sp_b", 1'b1, 2'd3, 32'hA000_0003, 4'b0010);
    cyc();
    req = 4'b0000;
    #1;
    chk_out("sp_c", 1'b1, 2'd1, 32'hA000_0001, 4'b0000);
    cyc();
    chk("sp_drain", 32'(valid), 32'h0);

    // ptr is 2: capture index 2, then stall 3 cycles.
    cyc();
    req = 4'b1111;
    #1;
    chk("st_gnt", 32'(gnt), 32'h4);
    cyc();
    ready = 1'b0;
    #1;
    chk_out("stall0", 1'b1, 2'd2, 32'hA000_0002, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk_out("stall", 1'b1, 2'd2, 32'hA000_0002, 4'b0000);
    end
    cyc();
    ready = 1'b1;
    #1;
    chk_out("unstall", 1'b1, 2'd2, 32'hA000_0002, 4'b1000);
    cyc();
    req = 4'b0000;
    #1;
    chk_out("unstall_n", 1'b1, 2'd3, 32'hA000_0003, 4'b0000);
    cyc();
    chk("unstall_drain", 32'(valid), 32'h0);

    // Single pulse on requester 2 (ptr 0).
    cyc();
    req = 4'b0100;
    #1;
    chk_out("pulse_g", 1'b0, 2'd3, 32'hA000_0003, 4'b0100);
    cyc();
    req = 4'b0000;
    #1;
    chk_out("pulse_v", 1'b1, 2'd2, 32'hA000_0002, 4'b0000);
    cyc();
    chk("pulse_e1", 32'(valid), 32'h0);
    cyc();
    chk("pulse_e2", 32'(valid), 32'h0);

    // Idle cycles leave ptr at 3; capture index 3.
    cyc();
    req = 4'b1111;
    #1;
    chk("idle_ptr_gnt", 32'(gnt), 32'h8);
    cyc();
    req = 4'b0000;
    #1;
    chk_out("pre_rst", 1'b1, 2'd3, 32'hA000_0003, 4'b0000);
    #2;
    rstn = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 2'd0, 32'h0, 4'b0000);
    cyc();
    #3;
    rstn = 1'b1;
    req  = 4'b1111;
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h1);

    // Move ptr to 1, then reset again; search must restart at 0.
    cyc();
    req = 4'b0000;
    #1;
    chk_out("pre_rst2", 1'b1, 2'd0, 32'hA000_0000, 4'b0000);
    #2;
    rstn = 1'b0;
    req  = 4'b1111;
    #1;
    chk_out("async_rst2", 1'b0, 2'd0, 32'h0, 4'b0000);
    cyc();
    #3;
    rstn = 1'b1;
    #1;
    chk("post_rst2_gnt", 32'(gnt), 32'h1);
    cyc();
    chk("post_rst2_sel", 32'(sel), 32'h0);
    chk("post_rst2_out", dout, 32'hA000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
